// File: rtl/spi_master.sv
// SPI master: single word per transfer, runtime CPOL/CPHA, clock divider and chip-select index.
// Optional LSB-first ordering is compiled in when SPI_MASTER_LSB_FIRST_EN is defined.
module spi_master #(
    parameter int DATA_W = 8,
    parameter int NCS    = 2,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel_in,
    input  logic [DIV_W-1:0]  div_in,
    input  logic              cpol_in,
    input  logic              cpha_in,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first_in,
`endif
    input  logic              miso_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sclk_out,
    output logic              mosi_out,
    output logic [NCS-1:0]    cs_n_out
);

    localparam int TOG_W = $clog2(2 * DATA_W + 1);
    localparam logic [TOG_W-1:0] LAST_TOG = TOG_W'(2 * DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_hcnt;
    logic [DIV_W-1:0]  r_div;
    logic [TOG_W-1:0]  r_tog;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [CS_W-1:0]   r_cs_sel;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_data_out;
    logic              r_sclk;
    logic              r_mosi;

    logic              w_lsb_start;
    logic              w_hdone;
    logic              w_lead;
    logic              w_last;
    logic [DATA_W-1:0] w_rx_next;
    logic [DATA_W-1:0] w_tx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_lsb_start = lsb_first_in;
`else
    assign w_lsb_start = 1'b0;
`endif

    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                   input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    // An out-of-range index leaves every line deasserted.
    function automatic logic [NCS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NCS-1:0] v;
        v = '1;
        for (int i = 0; i < NCS; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    assign w_hdone   = (r_hcnt == r_div);
    assign w_lead    = ~r_tog[0];
    assign w_last    = (r_tog == LAST_TOG);
    assign w_rx_next = shift_rx(r_rx, miso_in, r_lsb);
    assign w_tx_next = shift_tx(r_tx, r_lsb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hcnt     <= '0;
            r_div      <= '0;
            r_tog      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cs_sel   <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE) begin
                r_hcnt <= w_hdone ? '0 : r_hcnt + DIV_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_state  <= SETUP;
                        r_busy   <= 1'b1;
                        r_tx     <= data_in;
                        r_rx     <= '0;
                        r_cs_sel <= cs_sel_in;
                        r_div    <= div_in;
                        r_cpol   <= cpol_in;
                        r_cpha   <= cpha_in;
                        r_lsb    <= w_lsb_start;
                        r_sclk   <= cpol_in;
                        r_hcnt   <= '0;
                        r_tog    <= '0;
                        // CPHA=0 presents the first bit before any clock edge.
                        if (!cpha_in) r_mosi <= head_bit(data_in, w_lsb_start);
                    end
                end
                SETUP: begin
                    if (w_hdone) r_state <= XFER;
                end
                XFER: begin
                    if (w_hdone) begin
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + TOG_W'(1);
                        if (w_lead) begin
                            if (!r_cpha) begin
                                r_rx <= w_rx_next;
                            end else begin
                                r_mosi <= head_bit(r_tx, r_lsb);
                                r_tx   <= w_tx_next;
                            end
                        end else begin
                            if (r_cpha) begin
                                r_rx <= w_rx_next;
                            end else if (!w_last) begin
                                r_mosi <= head_bit(w_tx_next, r_lsb);
                                r_tx   <= w_tx_next;
                            end
                        end
                        // CPHA=1 takes its final sample on this same edge.
                        if (w_last) begin
                            r_state    <= HOLD;
                            r_data_out <= r_cpha ? w_rx_next : r_rx;
                        end
                    end
                end
                HOLD: begin
                    if (w_hdone) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_out = r_busy;
    assign done_out = r_done;
    assign data_out = r_data_out;
    assign sclk_out = r_sclk;
    assign mosi_out = r_mosi;
    assign cs_n_out = r_busy ? cs_decode(r_cs_sel) : {NCS{1'b1}};

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: a cycle-offset reference model predicts every output each cycle,
// with literal expectations for the directed scenarios.
module tb_spi_master;

    localparam int DW   = 8;
    localparam int NCS  = 3;
    localparam int DIVW = 8;
    localparam int CSW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_in;
    logic [DW-1:0]   data_in;
    logic [CSW-1:0]  cs_sel_in;
    logic [DIVW-1:0] div_in;
    logic            cpol_in;
    logic            cpha_in;
    logic            lsb_first_in;
    logic            miso_in;
    logic            busy_out;
    logic            done_out;
    logic [DW-1:0]   data_out;
    logic            sclk_out;
    logic            mosi_out;
    logic [NCS-1:0]  cs_n_out;

    logic loop_en;
    logic miso_rand;
    logic rand_miso;

    assign miso_in = loop_en ? mosi_out : miso_rand;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(DW), .NCS(NCS), .DIV_W(DIVW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .data_in   (data_in),
        .cs_sel_in (cs_sel_in),
        .div_in    (div_in),
        .cpol_in   (cpol_in),
        .cpha_in   (cpha_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_in (lsb_first_in),
`endif
        .miso_in   (miso_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .data_out  (data_out),
        .sclk_out  (sclk_out),
        .mosi_out  (mosi_out),
        .cs_n_out  (cs_n_out)
    );

    // Reference model: a transfer is described by its cycle offset since the first busy cycle.
    int             off;
    int             mdiv;
    logic [DW-1:0]  m_tx;
    logic [CSW-1:0] m_sel;
    logic           m_cpol, m_cpha, m_lsb;
    logic [DW-1:0]  m_rx, m_dout;
    logic           m_done, m_mosi;

    int vecs = 0;
    int errs = 0;
    int dcount = 0;

    task automatic model_reset();
        off = -1; mdiv = 0; m_tx = '0; m_sel = '0; m_cpol = 1'b0; m_cpha = 1'b0;
        m_lsb = 1'b0; m_rx = '0; m_dout = '0; m_done = 1'b0; m_mosi = 1'b0;
    endtask

    function automatic logic txbit(int i);
        return m_lsb ? m_tx[i] : m_tx[DW-1-i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int h, k, idx;
        logic e_sclk;
        logic [NCS-1:0] e_cs;
        h = mdiv + 1;
        e_cs = '1;
        e_sclk = m_cpol;
        idx = -1;
        if (off >= 0) begin
            for (int i = 0; i < NCS; i++) if (int'(m_sel) == i) e_cs[i] = 1'b0;
            if (off < h) begin
                if (!m_cpha) idx = 0;
            end else if (off < h + 2*DW*h) begin
                k = (off - h) / h;
                e_sclk = m_cpol ^ k[0];
                if (!m_cpha) idx = k / 2;
                else if (k >= 1) idx = (k - 1) / 2;
            end
        end
        if (idx >= 0) m_mosi = txbit(idx);
        chk("busy", 32'(busy_out), 32'(off >= 0));
        chk("done", 32'(done_out), 32'(m_done));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("sclk", 32'(sclk_out), 32'(e_sclk));
        chk("mosi", 32'(mosi_out), 32'(m_mosi));
        chk("cs_n", 32'(cs_n_out), 32'(e_cs));
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_adv();
        int h, rel, j, b;
        logic mi;
        h = mdiv + 1;
        mi = loop_en ? mosi_out : miso_rand;
        if (off >= 0) begin
            rel = off - h;
            if (off >= h && rel < 2*DW*h && ((rel + 1) % h) == 0) begin
                j = (rel + 1) / h;
                b = -1;
                if (!m_cpha && (j % 2) == 1) b = (j - 1) / 2;
                if (m_cpha && (j % 2) == 0) b = j / 2 - 1;
                if (b >= 0) m_rx[m_lsb ? b : DW-1-b] = mi;
            end
            if (off == h + 2*DW*h - 1) m_dout = m_rx;
            if (off == (2*DW + 2)*h - 1) begin
                off = -1; m_done = 1'b1;
            end else begin
                off++; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start_in) begin
                m_tx = data_in; m_sel = cs_sel_in; mdiv = int'(div_in);
                m_cpol = cpol_in; m_cpha = cpha_in; m_rx = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
                m_lsb = lsb_first_in;
`else
                m_lsb = 1'b0;
`endif
                off = 0;
            end
        end
    endtask

    task automatic cyc();
        if (done_out === 1'b1) dcount++;
        check_outputs();
        model_adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        start_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rand_miso) miso_rand = 1'($urandom_range(0, 1));
            cyc();
        end
    endtask

    task automatic begin_xfer(input logic [DW-1:0] d, input logic [CSW-1:0] sel,
                              input logic [DIVW-1:0] dv, input logic pol, input logic pha,
                              input logic lsb, input logic lp);
        data_in = d; cs_sel_in = sel; div_in = dv; cpol_in = pol; cpha_in = pha;
        lsb_first_in = lsb; loop_en = lp; start_in = 1'b1;
        cyc();
        start_in = 1'b0;
    endtask

    task automatic finish_xfer(input int mid, output int bcnt, output int rises, output int mhigh);
        int n;
        logic prev;
        bcnt = 0; rises = 0; mhigh = 0; n = 0;
        prev = sclk_out;
        while (done_out !== 1'b1 && n < 5000) begin
            if (busy_out) bcnt++;
            if (busy_out && mosi_out) mhigh++;
            if (sclk_out && !prev) rises++;
            prev = sclk_out;
            start_in = (n == mid);
            if (n == mid) begin
                data_in = ~data_in; div_in = div_in + 1; cpol_in = ~cpol_in; cs_sel_in = ~cs_sel_in;
            end
            if (rand_miso) miso_rand = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        start_in = 1'b0;
        if (done_out !== 1'b1) begin
            errs++;
            $display("FAIL xfer_timeout: done_out %0b after %0d cycles, expected 1", done_out, n);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_out), 32'h0);
        chk("rst_done", 32'(done_out), 32'h0);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_sclk", 32'(sclk_out), 32'h0);
        chk("rst_mosi", 32'(mosi_out), 32'h0);
        chk("rst_cs_n", 32'(cs_n_out), 32'h7);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int bc, rs, mh, d0, gap, lim;
        rst = 1'b1; start_in = 1'b0; data_in = '0; cs_sel_in = '0; div_in = '0;
        cpol_in = 1'b0; cpha_in = 1'b0; lsb_first_in = 1'b0;
        loop_en = 1'b0; miso_rand = 1'b0; rand_miso = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        idle(2);

        // Mode 0, H=1, loopback 0xA5
        begin_xfer(8'hA5, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_xfer(-1, bc, rs, mh);
        chk("m0_busy_cycles", 32'(bc), 32'd18);
        chk("m0_done_pulse", 32'(done_out), 32'h1);
        chk("m0_data", 32'(data_out), 32'hA5);
        d0 = dcount;
        idle(3);
        chk("m0_single_done", 32'(dcount - d0), 32'd1);

        // Mode 3, H=4, miso held high
        miso_rand = 1'b1;
        begin_xfer(8'h3C, 2'd0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        finish_xfer(-1, bc, rs, mh);
        chk("m3_busy_cycles", 32'(bc), 32'd72);
        chk("m3_rises", 32'(rs), 32'd8);
        chk("m3_data", 32'(data_out), 32'hFF);
        idle(2);
        chk("m3_sclk_idle", 32'(sclk_out), 32'h1);

        // Chip-select index 1, then out-of-range index 3
        begin_xfer(8'h81, 2'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cs1_active", 32'(cs_n_out), 32'h5);
        finish_xfer(-1, bc, rs, mh);
        idle(1);
        chk("cs1_idle", 32'(cs_n_out), 32'h7);
        begin_xfer(8'h42, 2'd3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cs3_none", 32'(cs_n_out), 32'h7);
        finish_xfer(-1, bc, rs, mh);
        chk("cs3_data", 32'(data_out), 32'h42);
        idle(1);

        // Start during XFER is ignored; start in the done cycle is taken
        begin_xfer(8'h96, 2'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        d0 = dcount;
        finish_xfer(9, bc, rs, mh);
        chk("ign_busy_cycles", 32'(bc), 32'd36);
        chk("ign_data", 32'(data_out), 32'h96);
        begin_xfer(8'h5C, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("b2b_busy", 32'(busy_out), 32'h1);
        chk("ign_one_done", 32'(dcount - d0), 32'd1);
        finish_xfer(-1, bc, rs, mh);
        chk("b2b_data", 32'(data_out), 32'h5C);
        idle(1);

        // Reset at bit 4, then a clean loopback transfer
        begin_xfer(8'h3C, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        lim = 0;
        while (off < 2 + 8*2 && lim < 200) begin
            cyc();
            lim++;
        end
        chk("pre_rst_busy", 32'(busy_out), 32'h1);
        do_reset();
        d0 = dcount;
        idle(4);
        chk("abort_no_done", 32'(dcount - d0), 32'd0);
        begin_xfer(8'h5A, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_xfer(-1, bc, rs, mh);
        chk("post_rst_data", 32'(data_out), 32'h5A);
        idle(1);

`ifdef SPI_MASTER_LSB_FIRST_EN
        begin_xfer(8'h01, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lsb_first_bit", 32'(mosi_out), 32'h1);
        finish_xfer(-1, bc, rs, mh);
        chk("lsb_mosi_high", 32'(mh), 32'd3);
        chk("lsb_data", 32'(data_out), 32'h01);
        idle(1);
`endif

        // Randomised transfers
        for (int t = 0; t < 60; t++) begin
            rand_miso = 1'b1;
            begin_xfer(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            finish_xfer(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, bc, rs, mh);
            chk("rnd_rises", 32'(rs), 32'(cpol_in ? 8 : 8));
            gap = $urandom_range(0, 3);
            idle(gap);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
